// File: rtl/drive_pkg.sv
// Shared encodings for the manual drive controller: FSM states, cmd byte layout
// and the bundle of raw driver inputs.
package drive_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_IDLE     = 2'b01,
    ST_STARTING = 2'b10,
    ST_MOVING   = 2'b11
  } drive_state_e;

  localparam logic [1:0] CMD_HDR = 2'b10;

  localparam int FWD     = 0;
  localparam int BACK    = 1;
  localparam int LEFT    = 2;
  localparam int RIGHT   = 3;
  localparam int PLACE   = 4;
  localparam int DESTROY = 5;

  localparam int NUM_IN = 10;

  // Field order fixes the bit position of each raw input in the debouncer array.
  typedef struct packed {
    logic destroy_barrier;
    logic place_barrier;
    logic turn_right;
    logic turn_left;
    logic reverse;
    logic brake;
    logic clutch;
    logic throttle;
    logic power_off;
    logic power_on;
  } drv_in_t;

  function automatic logic [7:0] pack_cmd(input logic [5:0] bits);
    return {CMD_HDR, bits};
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// 2-FF synchroniser followed by a debouncer: the output flips only after
// CYCLES consecutive synced samples disagree with it.
module input_debouncer #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    cnt_d  = '0;
    db_d   = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q == LAST) db_d = sync_q[1];
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign dout = db_q;
endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual drive controller: debounced inputs, power/start/move FSM, mileage and a
// periodic UART cmd byte. Define TURN_LAMP_BLINK_EN for blinking turn lamps.
module manual_drive_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned POWER_HOLD_CYCLES = 100000000,
  parameter int unsigned CMD_PERIOD_CYCLES = 1000000,
  parameter int unsigned MILE_TICK_CYCLES  = 100000000,
  parameter int unsigned MILEAGE_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 power_on,
  input  logic                 power_off,
  input  logic                 throttle,
  input  logic                 clutch,
  input  logic                 brake,
  input  logic                 reverse,
  input  logic                 turn_left,
  input  logic                 turn_right,
  input  logic                 place_barrier,
  input  logic                 destroy_barrier,
  output logic [1:0]           state,
  output logic                 reverse_gear,
  output logic                 left_lamp,
  output logic                 right_lamp,
  output logic [7:0]           cmd,
  output logic                 cmd_valid,
  output logic [MILEAGE_W-1:0] mileage
);
  localparam int HW = $clog2(POWER_HOLD_CYCLES + 1);
  localparam int PW = $clog2(CMD_PERIOD_CYCLES + 1);
  localparam int TW = $clog2(MILE_TICK_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(POWER_HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(CMD_PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(MILE_TICK_CYCLES - 1);

  logic [NUM_IN-1:0] raw_v, db_v;
  drv_in_t           db;

  assign raw_v = {destroy_barrier, place_barrier, turn_right, turn_left, reverse,
                  brake, clutch, throttle, power_off, power_on};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    input_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .din (raw_v[i]),
      .dout(db_v[i])
    );
  end
  assign db = drv_in_t'(db_v);

  drive_state_e         state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [PW-1:0]        per_q, per_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [MILEAGE_W-1:0] mile_q, mile_d;
  logic                 rg_q, rg_d, rev_prev_q, rev_prev_d, valid_q, valid_d;
  logic                 rev_rise, entering_off;

  always_comb begin
    state_d    = state_q;
    hold_d     = '0;
    rev_prev_d = db.reverse;
    rev_rise   = db.reverse & ~rev_prev_q;
    if (db.power_off) state_d = ST_OFF;
    else begin
      case (state_q)
        ST_OFF: if (db.power_on) begin
          if (hold_q == HOLD_LAST) state_d = ST_IDLE;
          else                     hold_d  = hold_q + HW'(1);
        end
        ST_IDLE:
          if (db.throttle & ~db.clutch)                   state_d = ST_OFF;
          else if (db.throttle & db.clutch & ~db.brake)   state_d = ST_STARTING;
        ST_STARTING:
          if (db.brake)                                   state_d = ST_IDLE;
          else if (db.throttle & ~db.clutch)              state_d = ST_MOVING;
        ST_MOVING:
          if (db.brake)                                   state_d = ST_IDLE;
          else if (~db.throttle | db.clutch)              state_d = ST_STARTING;
          else if (rev_rise & ~db.clutch)                 state_d = ST_OFF;
      endcase
    end
    entering_off = (state_d == ST_OFF) && (state_q != ST_OFF);

    rg_d = rg_q;
    if (state_d == ST_OFF)                                rg_d = 1'b0;
    else if (rev_rise & db.clutch & (state_q != ST_OFF))  rg_d = ~rg_q;

    // The OFF-entry strobe wins over the period count, which restarts from 0.
    per_d   = '0;
    valid_d = 1'b0;
    if (entering_off) valid_d = 1'b1;
    else if (state_q != ST_OFF) begin
      if (per_q == PER_LAST) valid_d = 1'b1;
      else                   per_d   = per_q + PW'(1);
    end

    tick_d = tick_q;
    mile_d = mile_q;
    if (state_q == ST_MOVING) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (mile_q != '1) mile_d = mile_q + MILEAGE_W'(1);
      end else tick_d = tick_q + TW'(1);
    end
    if (entering_off) mile_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_OFF;
      hold_q     <= '0;
      per_q      <= '0;
      tick_q     <= '0;
      mile_q     <= '0;
      rg_q       <= 1'b0;
      rev_prev_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      per_q      <= per_d;
      tick_q     <= tick_d;
      mile_q     <= mile_d;
      rg_q       <= rg_d;
      rev_prev_q <= rev_prev_d;
      valid_q    <= valid_d;
    end
  end

  logic       on, drive, moving;
  logic [1:0] turn, lamp;
  logic [5:0] bits;

  always_comb begin
    on      = state_q != ST_OFF;
    drive   = state_q inside {ST_STARTING, ST_MOVING};
    moving  = state_q == ST_MOVING;
    turn[0] = drive & db.turn_left & ~db.turn_right;
    turn[1] = drive & db.turn_right & ~db.turn_left;
    bits          = '0;
    bits[FWD]     = moving & ~rg_q;
    bits[BACK]    = moving & rg_q;
    bits[LEFT]    = turn[0];
    bits[RIGHT]   = turn[1];
    bits[PLACE]   = on & db.place_barrier;
    bits[DESTROY] = on & db.destroy_barrier;
  end

`ifdef TURN_LAMP_BLINK_EN
  logic [1:0]         ph_q, ph_d;
  logic [1:0][PW-1:0] bl_q, bl_d;

  // Phase parks high while the turn bit is low so each rise starts a fresh lit half-period.
  always_comb begin
    ph_d = ph_q;
    bl_d = bl_q;
    for (int i = 0; i < 2; i++) begin
      if (!turn[i]) begin
        ph_d[i] = 1'b1;
        bl_d[i] = '0;
      end else if (bl_q[i] == PER_LAST) begin
        ph_d[i] = ~ph_q[i];
        bl_d[i] = '0;
      end else bl_d[i] = bl_q[i] + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q <= '1;
      bl_q <= '0;
    end else begin
      ph_q <= ph_d;
      bl_q <= bl_d;
    end
  end

  assign lamp = turn & ph_q;
`else
  assign lamp = turn;
`endif

  assign state        = state_q;
  assign reverse_gear = rg_q;
  assign left_lamp    = lamp[0];
  assign right_lamp   = lamp[1];
  assign cmd          = pack_cmd(bits);
  assign cmd_valid    = valid_q;
  assign mileage      = mile_q;
endmodule
